fir_decim_avg: RTL and testbench

- Downstream stage of the 1-bit-input FIR filter.
- Consumes the filter's 20-bit unsigned output sample stream.
- Averages each block of 2^DECIM_LOG2 consecutive valid samples and emits one decimated sample per block over a valid/ready handshake.
- Provides a one-entry output register, overrun detection and a synchronous flush, so the filter can run every clock while a slower consumer drains results.

---
 rtl/fir_decim_avg.sv | 102 ++++++++++
 tb/tb_fir_decim_avg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_avg.sv
// Block-average decimator behind the 1-bit-input FIR: averages 2^DECIM_LOG2 valid samples
// into a one-entry valid/ready output register. Define FIR_DECIM_ROUND_EN for round-half-up.
module fir_decim_avg #(
   parameter int IN_W       = 20,
   parameter int DECIM_LOG2 = 3,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   din,
   input  logic              din_valid,
   input  logic              flush,
   output logic [IN_W-1:0]   dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              overrun,
   input  logic              clr_ovr,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam int N     = 1 << DECIM_LOG2;
   localparam int ACC_W = IN_W + DECIM_LOG2;
   localparam int PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

   localparam logic [PH_W-1:0]  LAST    = PH_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef FIR_DECIM_ROUND_EN
   // N/2 is zero for the passthrough case, so no special casing is needed there.
   localparam logic [ACC_W-1:0] RND = ACC_W'(N / 2);
`else
   localparam logic [ACC_W-1:0] RND = '0;
`endif

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] rsum;
   logic [PH_W-1:0]  phase;
   logic [IN_W-1:0]  result;
   logic             done;
   logic             load;
   logic             drop;

   // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
   always_comb begin
      sum    = acc + ACC_W'(din);
      rsum   = sum + RND;
      result = IN_W'(rsum >> DECIM_LOG2);
      done   = din_valid & ~flush & (phase == LAST);
      load   = done & (~dout_valid | dout_ready);
      drop   = done & dout_valid & ~dout_ready;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         phase <= '0;
      end else if (flush) begin
         acc   <= '0;
         phase <= '0;
      end else if (din_valid) begin
         if (phase == LAST) begin
            acc   <= '0;
            phase <= '0;
         end else begin
            acc   <= sum;
            phase <= phase + PH_W'(1);
         end
      end
   end

   // Output register: a completed handshake and a new load may share a cycle without a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (load) begin
         dout       <= result;
         dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

   // A drop in the same cycle as clr_ovr wins and restarts the count at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overrun <= 1'b1;
         if (clr_ovr)
            drop_cnt <= CNT_W'(1);
         else if (drop_cnt != CNT_MAX)
            drop_cnt <= drop_cnt + CNT_W'(1);
      end else if (clr_ovr) begin
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_fir_decim_avg.sv
// Self-checking bench for fir_decim_avg: directed scenarios plus randomized traffic, all
// compared each cycle against a block-list reference model (averages via integer division).
module tb_fir_decim_avg;

   localparam int IN_W       = 20;
   localparam int DECIM_LOG2 = 3;
   localparam int CNT_W      = 8;
   localparam int N          = 1 << DECIM_LOG2;
   localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [IN_W-1:0]   din = '0;
   logic              din_valid = 1'b0;
   logic              flush = 1'b0;
   logic [IN_W-1:0]   dout;
   logic              dout_valid;
   logic              dout_ready = 1'b0;
   logic              overrun;
   logic              clr_ovr = 1'b0;
   logic [CNT_W-1:0]  drop_cnt;

   fir_decim_avg #(.IN_W(IN_W), .DECIM_LOG2(DECIM_LOG2), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .flush(flush),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .overrun(overrun), .clr_ovr(clr_ovr), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the pending block is a plain list of samples.
   longint blk[$];
   longint m_dout = 0, m_cnt = 0;
   bit     m_valid = 0, m_ovr = 0;

`ifdef FIR_DECIM_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit rs, input bit v, input longint d, input bit f,
                        input bit r, input bit c);
      bit done = 0;
      longint res = 0, s = 0;
      if (rs) begin
         blk.delete(); m_dout = 0; m_valid = 0; m_ovr = 0; m_cnt = 0;
         return;
      end
      if (f) blk.delete();
      else if (v) begin
         blk.push_back(d);
         if (blk.size() == N) begin
            foreach (blk[i]) s += blk[i];
            if (ROUND) s += N / 2;
            res  = s / N;
            done = 1;
            blk.delete();
         end
      end
      if (done && m_valid && !r) begin
         m_ovr = 1;
         m_cnt = c ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);
      end else if (c) begin
         m_ovr = 0; m_cnt = 0;
      end
      if (done && (!m_valid || r)) begin
         m_dout = res; m_valid = 1;
      end else if (!done && m_valid && r) m_valid = 0;
   endtask

   // One clock: drive, advance the model, sample #1 after the edge and compare.
   task automatic step(input bit rs, input bit v, input logic [IN_W-1:0] d, input bit f,
                       input bit r, input bit c);
      rst = rs; din_valid = v; din = d; flush = f; dout_ready = r; clr_ovr = c;
      model(rs, v, longint'(d), f, r, c);
      @(posedge clk);
      #1;
      check("dout", dout, m_dout);
      check("dout_valid", dout_valid, m_valid);
      check("overrun", overrun, m_ovr);
      check("drop_cnt", drop_cnt, m_cnt);
   endtask

   task automatic feed(input int n, input logic [IN_W-1:0] d, input bit r);
      for (int i = 0; i < n; i++) step(0, 1, d, 0, r, 0);
   endtask

   task automatic idle(input bit r);
      step(0, 0, '0, 0, r, 0);
   endtask

   logic [IN_W-1:0] held;

   initial begin
      // Reset with input activity present.
      step(1, 1, 20'd500, 0, 0, 0);
      step(1, 1, 20'd500, 0, 0, 0);
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_ovr", overrun, 0);
      check("rst_cnt", drop_cnt, 0);

      feed(7, 20'd100, 1);
      check("lat_not_yet", dout_valid, 0);
      feed(1, 20'd100, 1);
      check("lat_dout", dout, 100);
      check("lat_valid", dout_valid, 1);

      // Rounding and full-scale.
      feed(7, 20'd0, 1);
      feed(1, 20'd4, 1);
      check("round_dout", dout, ROUND ? 1 : 0);
      feed(8, 20'hFFFFF, 1);
      check("fullscale", dout, 1048575);

      // Gapped input: valid on 8 of 20 cycles.
      idle(1);
      for (int i = 0; i < 20; i++) begin
         if (i % 5 == 0 || i % 5 == 3) step(0, 1, 20'd10, 0, 0, 0);
         else idle(0);
         if (i == 17) check("gap_pending", dout_valid, 0);
      end
      check("gap_dout", dout, 10);
      check("gap_valid", dout_valid, 1);
      check("gap_cnt", drop_cnt, 0);

      // Backpressure and overrun.
      idle(1);
      feed(8, 20'd7, 0);
      held = dout;
      feed(16, 20'd7, 0);
      check("bp_stable", dout, held);
      check("bp_dout", dout, 7);
      check("bp_ovr", overrun, 1);
      check("bp_cnt", drop_cnt, 2);
      idle(1);
      check("bp_drain", dout_valid, 0);
      step(0, 0, '0, 0, 0, 1);
      check("clr_ovr", overrun, 0);
      check("clr_cnt", drop_cnt, 0);

      // Same-cycle accept and load.
      feed(8, 20'd30, 0);
      feed(7, 20'd50, 0);
      feed(1, 20'd50, 1);
      check("acc_load_dout", dout, 50);
      check("acc_load_valid", dout_valid, 1);
      check("acc_load_cnt", drop_cnt, 0);

      // Flush discards the partial block and the same-cycle sample.
      idle(1);
      feed(5, 20'd200, 1);
      step(0, 1, 20'd999, 1, 1, 0);
      feed(8, 20'd16, 1);
      check("flush_dout", dout, 16);

      // Drop coinciding with clr_ovr, then counter saturation.
      feed(8, 20'd1, 0);
      feed(7, 20'd2, 0);
      step(0, 1, 20'd2, 0, 0, 1);
      check("drop_vs_clr", drop_cnt, 1);
      for (int b = 0; b < 260; b++) feed(8, IN_W'($urandom), 0);
      check("cnt_saturate", drop_cnt, CNT_MAX);
      step(0, 0, '0, 0, 1, 1);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, IN_W'($urandom),
              $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 29) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
